wb_coef_loader: RTL and testbench
=================================

# wb_coef_loader

Sequencer that loads a block of coefficients from an AXI-stream into a datapath module's Wishbone config port, then reads them back and verifies them. It sits between the coefficient source (host DMA or ROM streamer) and the `cyc/stb/we` control-register slave of a filter-style module. It reports busy, done and error, so system software can reprogram the datapath without driving Wishbone itself.

## Interface
Parameters:
- `CFGAW`, default 32: Wishbone address width.
- `CFGDW`, default 32: Wishbone data width.
- `COEFW`, default 18: coefficient width on the stream; must satisfy COEFW <= CFGDW.
- `NCOEF`, default 32: number of coefficients per load.
- `BASE_ADDR`, default 0: register index of coefficient 0.
- `TIMEOUT`, default 255: maximum number of cycles to wait for `ack_i`.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous reset, active-high.
- `start`, in, 1: starts a load; sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a load ends, successfully or not.
- `err`, out, 1: error flag; valid while `done` is high and held until the next `start`.
- `s_axis_tdata`, in, COEFW, signed: coefficient stream data.
- `s_axis_tvalid`, in, 1: coefficient stream valid.
- `s_axis_tready`, out, 1: coefficient stream ready.
- `cyc_o`, `stb_o`, `we_o`, out, 1 each: Wishbone master control.
- `ack_i`, `stall_i`, in, 1 each: Wishbone slave response.
- `addr_o`, out, CFGAW: register index.
- `data_o`, out, CFGDW, signed: write data.
- `data_i`, in, CFGDW, signed: read data.

## Operation
- States: IDLE, W_FETCH, W_REQ, W_ACK, R_REQ, R_ACK, FINISH.
- Index counter `idx` runs 0..NCOEF-1.
- Two accumulators, `wsum` and `rsum`, are CFGDW wide and wrap modulo 2^CFGDW.
- IDLE:
  - On `start`: clear `idx`, `wsum`, `rsum` and `err`; go to W_FETCH.
- W_FETCH:
  - `s_axis_tready`=1; `cyc_o`=1; `stb_o`=0.
  - On a stream handshake: latch the sign-extended data into `data_o`, add it to `wsum`, set `addr_o`=BASE_ADDR+idx and `we_o`=1; go to W_REQ.
- W_REQ:
  - `stb_o`=1; `addr_o` and `data_o` held.
  - If `stall_i`=0 on an edge, the request is accepted; go to W_ACK.
- W_ACK:
  - `stb_o`=0. Wait for `ack_i`.
  - On `ack_i`: if `idx`=NCOEF-1, clear `idx` and go to R_REQ; otherwise increment `idx` and go to W_FETCH.
- R_REQ:
  - `we_o`=0, `stb_o`=1, `addr_o`=BASE_ADDR+idx.
  - Accepted when `stall_i`=0; go to R_ACK.
- R_ACK:
  - On `ack_i`: add `data_i` to `rsum`.
  - Last index: go to FINISH. Otherwise increment `idx` and go to R_REQ.
- FINISH:
  - `cyc_o`=0; `done`=1 for one cycle; `err` |= (`wsum` != `rsum`); go to IDLE.
- Timeout:
  - A counter counts cycles spent in W_ACK or R_ACK and clears on entry to either state.
  - When it reaches TIMEOUT: set `err`, drop `cyc_o`/`stb_o`, go to FINISH.
  - No verification is done after a timeout. `err` stays 1.
- `cyc_o` stays high continuously from the entry to W_FETCH through the last R_ACK. It is low in IDLE and FINISH.
- `start` outside IDLE is ignored.
- At most one Wishbone transaction is outstanding at any time.
- An `ack_i` outside W_ACK/R_ACK is ignored.
- A stalled stream (`tvalid`=0 in W_FETCH) waits indefinitely. It is not covered by the timeout.

## Timing
- Reset: all outputs 0 (`busy`, `done`, `err`, `s_axis_tready`, `cyc_o`, `stb_o`, `we_o`, `addr_o`, `data_o`); state IDLE.
- Reset mid-load aborts the load: `cyc_o`=0 on the edge after `rst` is sampled, with no `done` pulse.
- `start` at edge N: `busy` and `cyc_o` go high after N, and `s_axis_tready` goes high in cycle N+1.
- With zero stall, an immediate ack and continuous `tvalid`:
  - each write takes 3 cycles (FETCH, REQ, ACK);
  - each read takes 2 cycles;
  - total `busy` time is 3·NCOEF + 2·NCOEF + 1 cycles including FINISH.
- The `done` pulse is coincident with `busy`=1 in FINISH; `busy`=0 the next cycle.
- Every output is registered.

## Test plan
- **Clean load.** NCOEF=4, BASE_ADDR=8. Stream 1, -2, 3, 131071; the slave is an echo register file.
  - Writes go to addresses 8..11 with data 0x00000001, 0xFFFFFFFE, 0x00000003, 0x0001FFFF.
  - Reads then follow in the same address order.
  - `done` pulses at cycle 21 with `err`=0.
- **Stall handling.** Hold `stall_i`=1 for 5 cycles in the first W_REQ.
  - `stb_o`, `addr_o` and `data_o` stay stable for those 5 cycles.
  - Exactly 4 writes and 4 reads are issued.
- **Verify mismatch.** The slave returns the written value +1 on read index 2.
  - `done` pulses with `err`=1.
  - `err` stays 1 until the next `start`, then clears.
- **Timeout.** TIMEOUT=10; the slave never acks the second write.
  - `cyc_o` drops 10 cycles after the W_ACK entry.
  - `done` pulses with `err`=1; no reads are issued.
- **Reset mid-read.** Assert `rst` during R_ACK of index 1.
  - `cyc_o`, `busy` and `stb_o` are 0 the next cycle; no `done` pulse occurs.
  - A subsequent `start` completes cleanly.
- **Start while busy, and stream gap.** Pulse `start` during W_ACK, and deassert `tvalid` for 7 cycles in W_FETCH.
  - No restart occurs; `cyc_o` stays high through the gap.
  - The load completes with `err`=0.

Source files
------------

// File: rtl/wb_coef_loader.sv
// Streams NCOEF coefficients into a Wishbone config slave, reads them back,
// and flags an error on checksum mismatch or a missing ack.
module wb_coef_loader #(
    parameter int CFGAW     = 32,
    parameter int CFGDW     = 32,
    parameter int COEFW     = 18,
    parameter int NCOEF     = 32,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic signed [COEFW-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    input  logic                    ack_i,
    input  logic                    stall_i,
    output logic [CFGAW-1:0]        addr_o,
    output logic signed [CFGDW-1:0] data_o,
    input  logic signed [CFGDW-1:0] data_i
);

    localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NCOEF - 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CFGAW-1:0] BASE     = CFGAW'(BASE_ADDR);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WFETCH = 3'd1;
    localparam logic [2:0] S_WREQ   = 3'd2;
    localparam logic [2:0] S_WACK   = 3'd3;
    localparam logic [2:0] S_RREQ   = 3'd4;
    localparam logic [2:0] S_RACK   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [TW-1:0]           to_q, to_d;
    logic [CFGDW-1:0]        wsum_q, wsum_d, rsum_q, rsum_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                    rdy_q, rdy_d, cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [CFGAW-1:0]        addr_q, addr_d;
    logic signed [CFGDW-1:0] data_q, data_d;
    logic signed [CFGDW-1:0] sx;
    logic                    last;

    assign sx   = s_axis_tdata;
    assign last = (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        to_d    = to_q;
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rdy_d   = 1'b0;
        stb_d   = 1'b0;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: if (start) begin
                idx_d   = '0;
                wsum_d  = '0;
                rsum_d  = '0;
                err_d   = 1'b0;
                cyc_d   = 1'b1;
                rdy_d   = 1'b1;
                state_d = S_WFETCH;
            end
            S_WFETCH: begin
                rdy_d = 1'b1;
                if (rdy_q && s_axis_tvalid) begin
                    data_d  = sx;
                    wsum_d  = wsum_q + sx;
                    addr_d  = BASE + CFGAW'(idx_q);
                    we_d    = 1'b1;
                    stb_d   = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = S_WREQ;
                end
            end
            S_WREQ, S_RREQ: begin
                if (!stall_i) begin
                    to_d    = '0;
                    state_d = (state_q == S_WREQ) ? S_WACK : S_RACK;
                end else begin
                    stb_d = 1'b1;
                end
            end
            S_WACK, S_RACK: begin
                if (ack_i) begin
                    if (state_q == S_RACK) begin
                        rsum_d = rsum_q + data_i;
                        if (last) begin
                            // Verify on the final ack so err is ready with done
                            err_d   = err_q | (wsum_q != rsum_d);
                            done_d  = 1'b1;
                            cyc_d   = 1'b0;
                            we_d    = 1'b0;
                            state_d = S_FINISH;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            addr_d  = BASE + CFGAW'(idx_d);
                            stb_d   = 1'b1;
                            state_d = S_RREQ;
                        end
                    end else if (last) begin
                        idx_d   = '0;
                        addr_d  = BASE;
                        we_d    = 1'b0;
                        stb_d   = 1'b1;
                        state_d = S_RREQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        rdy_d   = 1'b1;
                        state_d = S_WFETCH;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            to_q    <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign s_axis_tready = rdy_q;
    assign cyc_o         = cyc_q;
    assign stb_o         = stb_q;
    assign we_o          = we_q;
    assign addr_o        = addr_q;
    assign data_o        = data_q;

endmodule

// File: tb/tb_wb_coef_loader.sv
// Directed bench for wb_coef_loader: echo-register Wishbone slave, stream
// driver, transaction-level model and a per-cycle compare process.
module tb_wb_coef_loader;

    localparam int N  = 4;
    localparam int BA = 8;
    localparam int TO = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               busy, done, err;
    logic signed [17:0] s_axis_tdata = '0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic               cyc_o, stb_o, we_o;
    logic               ack_i = 1'b0;
    logic               stall_i = 1'b0;
    logic [31:0]        addr_o;
    logic signed [31:0] data_o;
    logic signed [31:0] data_i = '0;

    wb_coef_loader #(
        .CFGAW(32), .CFGDW(32), .COEFW(18), .NCOEF(N), .BASE_ADDR(BA), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .ack_i(ack_i), .stall_i(stall_i), .addr_o(addr_o), .data_o(data_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scenario knobs
    int cf [N];
    int drop_wr, bad_rd, stall_from, stall_len, restart_c, rst_c, gap_idx, gap_fetch;
    // model
    logic        exp_we   [16];
    logic [31:0] exp_addr [16];
    logic [31:0] exp_data [16];
    int          exp_n = 0;
    logic        exp_err;
    int          exp_cyc;
    // observed
    int k = 0, stb_cyc = 0, wr_cnt = 0, rd_cnt = 0, pop_cnt = 0, hold = 0;
    int sq[$];
    logic [31:0] mem [16];
    logic acc_n = 0, we_n = 0, hs_n = 0;
    logic [31:0] ad_n = 0, dt_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Wishbone slave: request accepted at an edge is acked in the following cycle
    always @(negedge clk) begin
        acc_n = stb_o && !stall_i;
        we_n  = we_o;
        ad_n  = addr_o;
        dt_n  = data_o;
        hs_n  = s_axis_tvalid && s_axis_tready;
    end

    always @(posedge clk) begin
        #1;
        ack_i = 1'b0;
        if (acc_n) begin
            if (we_n) begin
                mem[ad_n[3:0]] = dt_n;
                if (wr_cnt != drop_wr) ack_i = 1'b1;
                wr_cnt++;
            end else begin
                data_i = mem[ad_n[3:0]] + ((rd_cnt == bad_rd) ? 32'd1 : 32'd0);
                ack_i  = 1'b1;
                rd_cnt++;
            end
            acc_n = 1'b0;
        end
    end

    // stream source
    always @(posedge clk) begin
        int tmp;
        #1;
        if (hs_n) begin
            tmp = sq.pop_front();
            if (pop_cnt == gap_idx) hold = gap_fetch + 2;
            pop_cnt++;
            hs_n = 1'b0;
        end
        if (hold > 0) begin
            hold--;
            s_axis_tvalid = 1'b0;
        end else begin
            s_axis_tvalid = (sq.size() > 0);
            if (sq.size() > 0) begin
                tmp = sq[0];
                s_axis_tdata = tmp[17:0];
            end
        end
    end

    // per-cycle comparison against the expected transaction list
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((stb_o && !cyc_o) || (cyc_o && !busy)) begin
                errors++;
                $display("FAIL ctrl_inv stb=%0b cyc=%0b busy=%0b", stb_o, cyc_o, busy);
            end
            if (stb_o) begin
                stb_cyc++;
                checks++;
                if (k >= exp_n) begin
                    errors++;
                    $display("FAIL txn_extra idx=%0d act addr=%0h we=%0b exp none", k, addr_o, we_o);
                end else if (we_o !== exp_we[k] || addr_o !== exp_addr[k] ||
                             (exp_we[k] && data_o !== exp_data[k])) begin
                    errors++;
                    $display("FAIL txn%0d act we/addr/data=%0b/%0h/%0h exp=%0b/%0h/%0h",
                             k, we_o, addr_o, data_o, exp_we[k], exp_addr[k], exp_data[k]);
                end
                if (!stall_i) k++;
            end
            if (done) begin
                checks++;
                if (err !== exp_err || k != exp_n || cyc_o !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_state act err=%0b txns=%0d cyc=%0b busy=%0b exp err=%0b txns=%0d cyc=0 busy=1",
                             err, k, cyc_o, busy, exp_err, exp_n);
                end
            end
        end
    end

    task automatic prep();
        sq.delete();
        for (int i = 0; i < N; i++) sq.push_back(cf[i]);
        k = 0; stb_cyc = 0; wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; hold = 0;
        drop_wr = -1; bad_rd = -1; stall_from = 0; stall_len = 0;
        restart_c = 0; rst_c = 0; gap_idx = -1; gap_fetch = 0;
    endtask

    // Expected behaviour from the load rules, not from cycle mechanics
    task automatic build(input int to_wr);
        logic [31:0] ws, rs;
        exp_n = 0; ws = 0; rs = 0;
        for (int i = 0; i < N; i++) begin
            if (to_wr < 0 || i <= to_wr) begin
                exp_we[exp_n] = 1'b1; exp_addr[exp_n] = BA + i; exp_data[exp_n] = 32'(cf[i]);
                exp_n++;
            end
            ws = ws + 32'(cf[i]);
            rs = rs + 32'(cf[i]) + ((i == bad_rd) ? 32'd1 : 32'd0);
        end
        if (to_wr < 0)
            for (int i = 0; i < N; i++) begin
                exp_we[exp_n] = 1'b0; exp_addr[exp_n] = BA + i; exp_data[exp_n] = 0;
                exp_n++;
            end
        exp_err = (to_wr >= 0) || (ws != rs);
        exp_cyc = (to_wr >= 0) ? 3 * to_wr + 2 + TO + 1
                               : 5 * N + 1 + stall_len + gap_fetch;
    endtask

    task automatic run(input int budget, output int dcyc, output int low);
        dcyc = 0; low = 0;
        for (int c = 1; c <= budget; c++) begin
            stall_i = (c >= stall_from) && (c < stall_from + stall_len);
            start   = (c == restart_c);
            rst     = (c == rst_c);
            @(negedge clk);
            if (c == 1) chk("start_outs busy/cyc/rdy/err", {busy, cyc_o, s_axis_tready, err}, 4'b1110);
            if (done) begin dcyc = c; break; end
            if (!cyc_o || !busy) low++;
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        start   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load(input string nm, output int dcyc);
        int low;
        kick();
        run(200, dcyc, low);
        chk({nm, " done_cycle"}, dcyc, exp_cyc);
        chk({nm, " cyc_gaps"}, low, 0);
        @(negedge clk);
        chk({nm, " after_done busy/done"}, {busy, done}, 2'b00);
        chk({nm, " stb_cycles"}, stb_cyc, exp_n + stall_len);
        @(posedge clk); #1;
    endtask

    initial begin
        int dcyc, low, dn;
        cf[0] = 1; cf[1] = -2; cf[2] = 3; cf[3] = 131071;
        prep();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset ctrl", {busy, done, err, s_axis_tready, cyc_o, stb_o, we_o}, 7'b0);
        chk("reset addr", addr_o, 0);
        chk("reset data", data_o, 0);
        @(posedge clk); #1;

        // clean load
        prep(); build(-1);
        load("clean", dcyc);
        chk("clean literal_cycle", dcyc, 21);
        chk("clean mem8", mem[8], 32'h00000001);
        chk("clean mem9", mem[9], 32'hFFFFFFFE);
        chk("clean mem10", mem[10], 32'h00000003);
        chk("clean mem11", mem[11], 32'h0001FFFF);
        chk("clean wr/rd counts", {wr_cnt[7:0], rd_cnt[7:0]}, {8'd4, 8'd4});

        // stall in the first write request
        prep(); stall_from = 2; stall_len = 5; build(-1);
        load("stall", dcyc);
        chk("stall wr/rd counts", {wr_cnt[7:0], rd_cnt[7:0]}, {8'd4, 8'd4});

        // readback mismatch on read index 2
        prep(); bad_rd = 2; build(-1);
        load("mismatch", dcyc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mismatch err_held", {err, busy, done}, 3'b100);
        @(posedge clk); #1;

        // second write never acked
        prep(); drop_wr = 1; build(1);
        load("timeout", dcyc);
        chk("timeout literal_cycle", dcyc, 16);
        chk("timeout no_reads", rd_cnt, 0);
        chk("timeout err_held", err, 1'b1);

        // reset during R_ACK of index 1
        prep(); rst_c = 16; build(-1);
        kick();
        run(16, dcyc, low);
        rst = 1'b0;
        chk("rst_mid no_done_before", dcyc, 0);
        @(negedge clk);
        chk("rst_mid outs", {cyc_o, busy, stb_o, done, err}, 5'b0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_mid no_done_after", dn, 0);
        @(posedge clk); #1;
        prep(); build(-1);
        load("after_rst", dcyc);

        // start while busy plus a 7-cycle stream gap before coefficient 2
        prep(); restart_c = 3; gap_idx = 1; gap_fetch = 7; build(-1);
        load("gap", dcyc);
        chk("gap literal_cycle", dcyc, 28);
        chk("gap wr/rd counts", {wr_cnt[7:0], rd_cnt[7:0]}, {8'd4, 8'd4});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

endmodule
